// File: rtl/fwd_operand_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | fwd_operand_unit_pkg : shared forward-select encodings for the EX forwarder |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package fwd_operand_unit_pkg;
  localparam logic [1:0] c_sel_cap = 2'b00;  // operand captured at issue
  localparam logic [1:0] c_sel_mem = 2'b01;  // operand from EX/MEM buffer
  localparam logic [1:0] c_sel_wb  = 2'b10;  // operand from MEM/WB write-back
endpackage

`default_nettype wire

// File: rtl/fwd_operand_unit_src_sel.sv
// +----------------------------------------------------------------------------+
// | fwd_operand_unit_src_sel : match, priority and capture for one source      |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module fwd_operand_unit_src_sel
  import fwd_operand_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_accept,
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_ex_valid,
  input  logic              i_ex_we,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_ex_dst,
  input  logic              i_mem_valid,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_wb_valid,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic              i_op_en,
  output logic              o_load_hit,
  output logic [1:0]        o_sel,
  output logic [DATA_W-1:0] o_op
);

  logic              w_src_zero;
  logic              w_hit_ex;
  logic              w_hit_mem;
  logic              w_hit_wb;
  logic [1:0]        w_sel_nxt;
  logic [DATA_W-1:0] w_cap_nxt;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_cap;

  assign w_src_zero = (ZERO_REG != 0) && (i_src == '0);
  assign w_hit_ex   = i_ex_valid  & i_ex_we  & (i_ex_dst  == i_src) & ~w_src_zero;
  assign w_hit_mem  = i_mem_valid & i_mem_we & (i_mem_dst == i_src) & ~w_src_zero;
  assign w_hit_wb   = i_wb_valid  & i_wb_we  & (i_wb_dst  == i_src) & ~w_src_zero;
  assign o_load_hit = w_hit_ex & i_ex_is_load;

  // Youngest producer wins; a WB hit is bypassed because the RF read misses it.
  always_comb begin
    w_sel_nxt = c_sel_cap;
    w_cap_nxt = i_rf_data;
    if (w_hit_ex) begin
      w_sel_nxt = c_sel_mem;
    end else if (w_hit_mem) begin
      w_sel_nxt = c_sel_wb;
    end else if (w_hit_wb) begin
      w_cap_nxt = i_wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel <= c_sel_cap;
      r_cap <= '0;
    end else if (i_accept) begin
      r_sel <= w_sel_nxt;
      r_cap <= w_cap_nxt;
    end else begin
      r_sel <= c_sel_cap;
      r_cap <= '0;
    end
  end

  always_comb begin
    o_op  = '0;
    o_sel = c_sel_cap;
    if (i_op_en) begin
      o_sel = r_sel;
      case (r_sel)
        c_sel_mem: o_op = i_mem_data;
        c_sel_wb:  o_op = i_wb_data;
        default:   o_op = r_cap;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_operand_unit.sv
// +----------------------------------------------------------------------------+
// | fwd_operand_unit : EX-stage operand forwarding with load-use stall          |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module fwd_operand_unit
  import fwd_operand_unit_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int NUM_SRC  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_issue_valid,
  input  logic                      in_issue_is_load,
  input  logic                      in_issue_dst_we,
  input  logic [REG_AW-1:0]         in_issue_dst,
  input  logic [NUM_SRC*REG_AW-1:0] in_issue_src,
  input  logic [NUM_SRC*DATA_W-1:0] in_rf_data,
  input  logic [DATA_W-1:0]         in_mem_data,
  input  logic [DATA_W-1:0]         in_wb_data,
  input  logic                      in_flush,
  output logic                      out_stall,
  output logic                      out_ex_valid,
  output logic [NUM_SRC*DATA_W-1:0] out_op,
  output logic [NUM_SRC*2-1:0]      out_fwd_sel,
  output logic [REG_AW-1:0]         out_ex_dst,
  output logic                      out_ex_dst_we,
  output logic                      out_ex_is_load
);

  logic               r_ex_valid;
  logic               r_ex_we;
  logic               r_ex_is_load;
  logic [REG_AW-1:0]  r_ex_dst;
  logic               r_mem_valid;
  logic               r_mem_we;
  logic [REG_AW-1:0]  r_mem_dst;
  logic               r_wb_valid;
  logic               r_wb_we;
  logic [REG_AW-1:0]  r_wb_dst;
  logic [NUM_SRC-1:0] w_load_hit;
  logic               w_accept;

  // Flush wins over a load-use hit: nothing is held if the issue is squashed anyway.
  assign out_stall = in_issue_valid & ~in_flush & (|w_load_hit);
  assign w_accept  = in_issue_valid & ~in_flush & ~(|w_load_hit);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_we      <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_dst     <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_dst    <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_dst     <= '0;
    end else begin
      r_ex_valid   <= w_accept;
      r_ex_we      <= w_accept & in_issue_dst_we;
      r_ex_is_load <= w_accept & in_issue_is_load;
      r_ex_dst     <= (w_accept & in_issue_dst_we) ? in_issue_dst : '0;
      r_mem_valid  <= r_ex_valid & ~in_flush;
      r_mem_we     <= r_ex_we;
      r_mem_dst    <= r_ex_dst;
      r_wb_valid   <= r_mem_valid;
      r_wb_we      <= r_mem_we;
      r_wb_dst     <= r_mem_dst;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_operand_unit_src_sel #(
      .DATA_W   (DATA_W),
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
    ) u_src_sel (
      .i_clk        (in_clk),
      .i_rst_n      (in_rst_n),
      .i_accept     (w_accept),
      .i_src        (in_issue_src[k*REG_AW +: REG_AW]),
      .i_rf_data    (in_rf_data[k*DATA_W +: DATA_W]),
      .i_mem_data   (in_mem_data),
      .i_wb_data    (in_wb_data),
      .i_ex_valid   (r_ex_valid),
      .i_ex_we      (r_ex_we),
      .i_ex_is_load (r_ex_is_load),
      .i_ex_dst     (r_ex_dst),
      .i_mem_valid  (r_mem_valid),
      .i_mem_we     (r_mem_we),
      .i_mem_dst    (r_mem_dst),
      .i_wb_valid   (r_wb_valid),
      .i_wb_we      (r_wb_we),
      .i_wb_dst     (r_wb_dst),
      .i_op_en      (r_ex_valid),
      .o_load_hit   (w_load_hit[k]),
      .o_sel        (out_fwd_sel[k*2 +: 2]),
      .o_op         (out_op[k*DATA_W +: DATA_W])
    );
  end

  assign out_ex_valid   = r_ex_valid;
  assign out_ex_dst     = r_ex_dst;
  assign out_ex_dst_we  = r_ex_we;
  assign out_ex_is_load = r_ex_is_load;

endmodule

`default_nettype wire

// File: tb/tb_fwd_operand_unit.sv
// +----------------------------------------------------------------------------+
// | tb_fwd_operand_unit : program-order value model versus the forwarding unit  |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fwd_operand_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_is_load, issue_dst_we, flush;
  logic [2:0]  issue_dst;
  logic [5:0]  issue_src;
  logic [31:0] rf_data;
  logic [15:0] mem_data, wb_data;
  logic        stall, ex_valid, ex_dst_we, ex_is_load;
  logic [31:0] op;
  logic [3:0]  fwd_sel;
  logic [2:0]  ex_dst;

  always #5 clk = ~clk;

  fwd_operand_unit #(.DATA_W(16), .REG_AW(3), .NUM_SRC(2), .ZERO_REG(1)) dut (
    .in_clk           (clk),
    .in_rst_n         (rst_n),
    .in_issue_valid   (issue_valid),
    .in_issue_is_load (issue_is_load),
    .in_issue_dst_we  (issue_dst_we),
    .in_issue_dst     (issue_dst),
    .in_issue_src     (issue_src),
    .in_rf_data       (rf_data),
    .in_mem_data      (mem_data),
    .in_wb_data       (wb_data),
    .in_flush         (flush),
    .out_stall        (stall),
    .out_ex_valid     (ex_valid),
    .out_op           (op),
    .out_fwd_sel      (fwd_sel),
    .out_ex_dst       (ex_dst),
    .out_ex_dst_we    (ex_dst_we),
    .out_ex_is_load   (ex_is_load)
  );

  // One in-flight instruction with the operand values program order says it must see.
  typedef struct packed {
    logic             v;
    logic             we;
    logic             ld;
    logic [2:0]       dst;
    logic [15:0]      res;
    logic [1:0][15:0] eop;
    logic [1:0][1:0]  esel;
  } slot_t;

  slot_t       pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
  logic [15:0] rf [8];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Latest writer in program order wins; which stage it sits in tells where the data arrives.
  task automatic lookup(input logic [2:0] src, input logic [15:0] rf_val,
                        output logic [15:0] val, output logic [1:0] sel, output bit haz);
    val = rf_val;
    sel = 2'b00;
    haz = 1'b0;
    if (src != 3'd0) begin
      for (int s = 2; s >= 0; s--) begin
        if (pipe[s].v && pipe[s].we && pipe[s].dst == src) begin
          val = pipe[s].res;
          sel = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : 2'b00;
          haz = (s == 0) && pipe[s].ld;
        end
      end
    end
  endtask

  task automatic check_ex();
    check_eq("ex_valid", ex_valid, pipe[0].v);
    if (pipe[0].v) begin
      check_eq("op0", op[15:0], pipe[0].eop[0]);
      check_eq("op1", op[31:16], pipe[0].eop[1]);
      check_eq("fwd_sel", fwd_sel, pipe[0].esel);
      check_eq("ex_dst_we", ex_dst_we, pipe[0].we);
      check_eq("ex_is_load", ex_is_load, pipe[0].ld);
      if (pipe[0].we) check_eq("ex_dst", ex_dst, pipe[0].dst);
    end else begin
      check_eq("op_idle", op, 32'h0);
      check_eq("sel_idle", fwd_sel, 4'h0);
    end
  endtask

  task automatic step(input bit v, input bit ld, input bit we, input logic [2:0] dst,
                      input logic [2:0] s0, input logic [2:0] s1, input bit fl,
                      input logic [15:0] res, output bit stalled);
    slot_t       nw;
    logic [15:0] v0, v1;
    logic [1:0]  e0, e1;
    bit          h0, h1;
    issue_valid   = v;
    issue_is_load = ld;
    issue_dst_we  = we;
    issue_dst     = dst;
    issue_src     = {s1, s0};
    flush         = fl;
    rf_data       = {rf[s1], rf[s0]};
    mem_data = (pipe[1].v && pipe[1].we && !pipe[1].ld) ? pipe[1].res : 16'($urandom);
    wb_data  = (pipe[2].v && pipe[2].we) ? pipe[2].res : 16'($urandom);
    lookup(s0, rf[s0], v0, e0, h0);
    lookup(s1, rf[s1], v1, e1, h1);
    nw      = '0;
    nw.v    = 1'b1;
    nw.we   = we;
    nw.ld   = ld;
    nw.dst  = dst;
    nw.res  = res;
    nw.eop  = {v1, v0};
    nw.esel = {e1, e0};
    stalled = v && !fl && (h0 || h1);
    #2;
    check_eq("stall", stall, stalled);
    check_ex();
    @(posedge clk);
    #1;
    if (pipe[2].v && pipe[2].we) rf[pipe[2].dst] = pipe[2].res;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (fl) pipe[1].v = 1'b0;
    pipe[0] = (v && !fl && !stalled) ? nw : '0;
  endtask

  task automatic reset_pulse();
    issue_valid   = 1'($urandom);
    issue_is_load = 1'($urandom);
    issue_dst_we  = 1'($urandom);
    issue_dst     = 3'($urandom);
    issue_src     = 6'($urandom);
    rf_data       = $urandom;
    mem_data      = 16'($urandom);
    wb_data       = 16'($urandom);
    flush         = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ex_valid", ex_valid, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_op", op, 32'h0);
    check_eq("rst_sel", fwd_sel, 4'h0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_valid", ex_valid, 1'b0);
    check_eq("rst_hold_op", op, 32'h0);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
  endtask

  bit         st;
  bit         cv, cl, cw, cf;
  logic [2:0] cd, c0, c1;
  logic [15:0] cr;

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
    @(posedge clk);
    #1;
    reset_pulse();

    // forward from EX/MEM buffer
    rf[3] = 16'h0000;
    step(1, 0, 1, 3'd3, 3'd0, 3'd0, 0, 16'h408D, st);
    step(1, 0, 0, 3'd0, 3'd3, 3'd1, 0, 16'h0001, st);
    step(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, st);
    // forward from MEM/WB
    step(1, 0, 1, 3'd5, 3'd0, 3'd0, 0, 16'hFF55, st);
    step(1, 0, 1, 3'd1, 3'd0, 3'd0, 0, 16'h0002, st);
    step(1, 0, 0, 3'd0, 3'd0, 3'd5, 0, 16'h0003, st);
    step(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, st);
    // same-cycle writeback bypass
    rf[2] = 16'h1111;
    step(1, 0, 1, 3'd2, 3'd0, 3'd0, 0, 16'h0EA8, st);
    step(1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0004, st);
    step(1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0005, st);
    step(1, 0, 0, 3'd0, 3'd2, 3'd0, 0, 16'h0006, st);
    step(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, st);
    // load-use: one stall then forward from WB
    step(1, 1, 1, 3'd4, 3'd0, 3'd0, 0, 16'h5E8D, st);
    step(1, 0, 0, 3'd0, 3'd4, 3'd0, 0, 16'h0007, st);
    check_eq("lu_stalled", st, 1'b1);
    step(1, 0, 0, 3'd0, 3'd4, 3'd0, 0, 16'h0007, st);
    check_eq("lu_retry", st, 1'b0);
    step(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, st);
    // youngest-first priority and zero register
    step(1, 0, 1, 3'd0, 3'd0, 3'd0, 0, 16'hAAAA, st);
    step(1, 0, 1, 3'd6, 3'd0, 3'd0, 0, 16'h6661, st);
    step(1, 0, 1, 3'd6, 3'd0, 3'd0, 0, 16'h6662, st);
    step(1, 0, 0, 3'd0, 3'd6, 3'd0, 0, 16'h0008, st);
    step(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, st);
    // flush during load-use
    step(1, 1, 1, 3'd4, 3'd0, 3'd0, 0, 16'h4444, st);
    step(1, 0, 0, 3'd0, 3'd4, 3'd0, 1, 16'h0009, st);
    step(1, 0, 0, 3'd0, 3'd4, 3'd4, 0, 16'h000A, st);
    step(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, st);
    // reset mid-stream, then RF data must be used
    step(1, 0, 1, 3'd7, 3'd0, 3'd0, 0, 16'h7777, st);
    reset_pulse();
    step(1, 0, 0, 3'd0, 3'd7, 3'd7, 0, 16'h000B, st);
    step(0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 16'h0000, st);

    // randomized traffic; a stalled instruction is re-presented unchanged
    st = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!st) begin
        cv = ($urandom_range(0, 9) < 8);
        cl = ($urandom_range(0, 9) < 3);
        cw = ($urandom_range(0, 9) < 8);
        cd = 3'($urandom);
        c0 = 3'($urandom);
        c1 = 3'($urandom);
        cr = 16'($urandom);
      end
      cf = ($urandom_range(0, 15) == 0);
      if (i == 700) reset_pulse();
      step(cv, cl, cw, cd, c0, c1, cf, cr, st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
